spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 20 ++
 rtl/spi_slave.sv | 131 +++++++++++++
 tb/tb_spi_slave.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave bus: serial pins plus parallel rx/tx side
interface spi_slave_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - 10-bit command/payload SPI slave with read-data reply
// Optional embedded assertions: define SPI_SLAVE_ASSERT_EN.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_bit_cnt;
    logic [8:0] r_shift;
    logic [9:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_addr_rcvd;
    logic       r_tx_wait;
    logic [7:0] r_tx_buf;
    logic [3:0] r_tx_cnt;
    logic       r_miso;

    logic w_in_word;
    logic w_abort;
    logic w_shift_en;
    logic w_word_done;

    assign w_in_word   = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
    assign w_abort     = (r_state != IDLE) && bus.SS_n;
    // A count of 10 marks the word complete; further MOSI bits are dropped.
    assign w_shift_en  = w_in_word && !bus.SS_n && (r_bit_cnt < 4'd10);
    assign w_word_done = w_shift_en && (r_bit_cnt == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!bus.SS_n) w_next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)          w_next_state = IDLE;
                else if (!bus.MOSI)    w_next_state = WRITE;
                else if (r_addr_rcvd)  w_next_state = READ_DATA;
                else                   w_next_state = READ_ADD;
            end
            default: begin
                if (bus.SS_n) w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 9'd0;
            r_rx_data   <= 10'd0;
            r_rx_valid  <= 1'b0;
            r_addr_rcvd <= 1'b0;
            r_tx_wait   <= 1'b0;
            r_tx_buf    <= 8'd0;
            r_tx_cnt    <= 4'd0;
            r_miso      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_abort) begin
                r_bit_cnt <= 4'd0;
                r_shift   <= 9'd0;
                r_tx_wait <= 1'b0;
                r_tx_cnt  <= 4'd0;
                r_miso    <= 1'b0;
            end else begin
                if (r_state == CHK_CMD) begin
                    r_shift   <= {r_shift[7:0], bus.MOSI};
                    r_bit_cnt <= 4'd1;
                end else if (w_shift_en) begin
                    r_shift   <= {r_shift[7:0], bus.MOSI};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end

                if (w_word_done) begin
                    r_rx_data  <= {r_shift, bus.MOSI};
                    r_rx_valid <= 1'b1;
                    if (r_state == READ_ADD)  r_addr_rcvd <= 1'b1;
                    if (r_state == READ_DATA) begin
                        r_addr_rcvd <= 1'b0;
                        r_tx_wait   <= 1'b1;
                    end
                end

                // Reply bits leave MSB first, starting the cycle after the latch.
                if (r_tx_wait && bus.tx_valid) begin
                    r_tx_buf  <= bus.tx_data;
                    r_tx_cnt  <= 4'd8;
                    r_tx_wait <= 1'b0;
                end else if (r_tx_cnt != 4'd0) begin
                    r_tx_buf <= {r_tx_buf[6:0], 1'b0};
                    r_tx_cnt <= r_tx_cnt - 4'd1;
                end

                if (r_tx_cnt != 4'd0) r_miso <= r_tx_buf[7];
                else                  r_miso <= 1'b0;
            end
        end
    end

    assign bus.MISO     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_ASSERT_EN
    a_reset_clears: assert property (@(posedge clk)
        !rst_n |=> (r_miso == 1'b0 && r_rx_valid == 1'b0 && r_rx_data == 10'd0));
    a_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
        r_rx_valid |=> !r_rx_valid);
`else
    // built without embedded checks
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - table-driven frame vectors plus abort/reset sequences
module tb_spi_slave;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    spi_slave_if bus ();

    spi_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dummy;
        logic [9:0] word;
        logic [7:0] tx;
        logic       exp_read;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic dummy, input logic [9:0] word,
                             input logic [7:0] tx, input logic exp_read);
        bus.SS_n = 1'b0;
        bus.MOSI = dummy;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = word[i];
            tick();
            if (i > 0) check("rx_valid_early", {9'd0, bus.rx_valid}, 10'd0);
        end
        check("rx_valid_pulse", {9'd0, bus.rx_valid}, 10'd1);
        check("rx_data", bus.rx_data, word);
        bus.MOSI = ~word[0];
        tick();
        check("rx_valid_one_cycle", {9'd0, bus.rx_valid}, 10'd0);
        check("rx_data_held", bus.rx_data, word);
        bus.tx_data  = tx;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        check("miso_at_latch", {9'd0, bus.MISO}, 10'd0);
        for (int k = 7; k >= 0; k--) begin
            tick();
            check("miso_bit", {9'd0, bus.MISO}, exp_read ? {9'd0, tx[k]} : 10'd0);
        end
        tick();
        check("miso_after_reply", {9'd0, bus.MISO}, 10'd0);
        bus.SS_n = 1'b1;
        tick();
        check("end_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
        check("end_miso", {9'd0, bus.MISO}, 10'd0);
    endtask

    task automatic abort_frame(input logic [9:0] word, input int nbits, input logic [9:0] held);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = word[9 - i];
            tick();
            check("abort_rx_valid_mid", {9'd0, bus.rx_valid}, 10'd0);
        end
        bus.SS_n = 1'b1;
        bus.MOSI = word[9 - nbits];
        tick();
        check("abort_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
        check("abort_miso", {9'd0, bus.MISO}, 10'd0);
        check("abort_rx_data_kept", bus.rx_data, held);
        tick();
        check("abort_idle_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{dummy: 1'b0, word: 10'h0A5, tx: 8'h5A, exp_read: 1'b0};
        vecs[1] = '{dummy: 1'b0, word: 10'h13C, tx: 8'hFF, exp_read: 1'b0};
        vecs[2] = '{dummy: 1'b1, word: 10'h307, tx: 8'h33, exp_read: 1'b0};
        vecs[3] = '{dummy: 1'b1, word: 10'h3C9, tx: 8'hB6, exp_read: 1'b1};
        vecs[4] = '{dummy: 1'b0, word: 10'h2F0, tx: 8'h81, exp_read: 1'b0};
        vecs[5] = '{dummy: 1'b0, word: 10'h355, tx: 8'h81, exp_read: 1'b1};

        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_miso", {9'd0, bus.MISO}, 10'd0);
        check("reset_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
        check("reset_rx_data", bus.rx_data, 10'd0);
        tick();

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].dummy, vecs[v].word, vecs[v].tx, vecs[v].exp_read);
        end

        abort_frame(10'h1AB, 5, 10'h355);
        abort_frame(10'h0FF, 9, 10'h355);
        run_frame(1'b0, 10'h1A3, 8'h00, 1'b0);

        run_frame(1'b1, 10'h211, 8'h00, 1'b0);
        abort_frame(10'h3FF, 5, 10'h211);
        run_frame(1'b1, 10'h3AA, 8'h4D, 1'b1);

        bus.SS_n = 1'b0;
        bus.MOSI = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = i[0];
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("midreset_async_rx_data", bus.rx_data, 10'd0);
        tick();
        check("midreset_miso", {9'd0, bus.MISO}, 10'd0);
        check("midreset_rx_valid", {9'd0, bus.rx_valid}, 10'd0);
        check("midreset_rx_data", bus.rx_data, 10'd0);
        bus.SS_n = 1'b1;
        rst_n    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_no_valid", {9'd0, bus.rx_valid}, 10'd0);
        end
        run_frame(1'b0, 10'h0A5, 8'h00, 1'b0);
        run_frame(1'b1, 10'h307, 8'h00, 1'b0);
        run_frame(1'b1, 10'h300, 8'hB6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
